// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop sync, per-channel debounce and one-cycle press strobe.
// Define BTN_REPEAT_EN to add hold-to-repeat strobes on held buttons.
`timescale 1ns/1ps

module btn_chan #(
  parameter int DB_CYCLES     = 16,
  parameter int CNT_W         = 20,
  parameter int REPEAT_DELAY  = 32,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic inclk,
  input  logic res_n,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || DB_CYCLES > (2 ** CNT_W) ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY ||
      REPEAT_DELAY > (2 ** CNT_W)) begin : g_bad_cfg
    $error("btn_chan: inconsistent debounce/repeat parameters");
  end

  logic             s1_q, s2_q;
  logic             lvl_q, lvl_d;
  logic             pls_q, pls_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             press;

  // Any agreement between sample and accepted level restarts the stability window.
  always_comb begin
    lvl_d  = lvl_q;
    dcnt_d = '0;
    if (s2_q != lvl_q) begin
      if (dcnt_q == DB_LAST) lvl_d  = s2_q;
      else                   dcnt_d = dcnt_q + 1'b1;
    end
  end

  assign press = lvl_d & ~lvl_q;

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             rpt;

  // Reload keeps the counter below RD_LAST+1, so it never wraps.
  always_comb begin
    hcnt_d = '0;
    rpt    = 1'b0;
    if (lvl_q && lvl_d) begin
      if (hcnt_q == RD_LAST) begin
        rpt    = 1'b1;
        hcnt_d = RELOAD;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge inclk or negedge res_n) begin
    if (!res_n) hcnt_q <= '0;
    else        hcnt_q <= hcnt_d;
  end

  assign pls_d = press | rpt;
`else
  assign pls_d = press;
`endif

  always_ff @(posedge inclk or negedge res_n) begin
    if (!res_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      dcnt_q <= '0;
      pls_q  <= 1'b0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      dcnt_q <= dcnt_d;
      pls_q  <= pls_d;
    end
  end

  assign level_o = lvl_q;
  assign pulse_o = pls_q;
endmodule

module btn_conditioner #(
  parameter int NBTN          = 3,
  parameter int DB_CYCLES     = 16,
  parameter int CNT_W         = 20,
  parameter int REPEAT_DELAY  = 32,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic            inclk,
  input  logic            res_n,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_pulse
);
  btn_chan #(
    .DB_CYCLES    (DB_CYCLES),
    .CNT_W        (CNT_W),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_chan [NBTN-1:0] (
    .inclk  (inclk),
    .res_n  (res_n),
    .raw_i  (btn_raw),
    .level_o(btn_level),
    .pulse_o(btn_pulse)
  );
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (default build): press, bounce, multi-channel, release, reset.
`timescale 1ns/1ps

module tb_btn_conditioner;
  localparam int NBTN = 3;
  localparam int DB   = 16;
  localparam int ACC  = DB + 2;

  logic            inclk = 1'b0;
  logic            res_n = 1'b0;
  logic [NBTN-1:0] btn_raw = '0;
  logic [NBTN-1:0] btn_level, btn_pulse;

  int n_chk = 0;
  int n_err = 0;

  always #5 inclk = ~inclk;

  btn_conditioner #(
    .NBTN(NBTN), .DB_CYCLES(DB), .CNT_W(20), .REPEAT_DELAY(32), .REPEAT_PERIOD(8)
  ) dut (
    .inclk    (inclk),
    .res_n    (res_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge inclk);
    #1;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_level", 32'(btn_level), 32'h0);
    chk("rst_pulse", 32'(btn_pulse), 32'h0);
    res_n = 1'b1;

    // clean press on ch1, held 50 cycles, then release
    btn_raw = 3'b010;
    for (int k = 1; k <= 50; k++) begin
      step();
      chk($sformatf("press_pulse@%0d", k), 32'(btn_pulse), (k == ACC) ? 32'h2 : 32'h0);
      chk($sformatf("press_level@%0d", k), 32'(btn_level), (k >= ACC) ? 32'h2 : 32'h0);
    end
    btn_raw = 3'b000;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("rel_pulse@%0d", k), 32'(btn_pulse), 32'h0);
      chk($sformatf("rel_level@%0d", k), 32'(btn_level), (k < ACC) ? 32'h2 : 32'h0);
    end

    // bounce on ch2: toggles every 5 cycles for 60 cycles, then holds high
    for (int seg = 0; seg < 12; seg++) begin
      btn_raw[2] = (seg % 2 == 0);
      for (int j = 0; j < 5; j++) begin
        step();
        chk($sformatf("bnc_pulse@%0d.%0d", seg, j), 32'(btn_pulse), 32'h0);
        chk($sformatf("bnc_level@%0d.%0d", seg, j), 32'(btn_level), 32'h0);
      end
    end
    btn_raw[2] = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      chk($sformatf("bnc_final_pulse@%0d", k), 32'(btn_pulse), (k == ACC) ? 32'h4 : 32'h0);
    end
    btn_raw = 3'b000;
    repeat (20) step();
    chk("bnc_idle_level", 32'(btn_level), 32'h0);

    // ch0 and ch2 together, ch1 three cycles later
    btn_raw = 3'b101;
    for (int k = 1; k <= 25; k++) begin
      if (k == 4) btn_raw = 3'b111;
      step();
      chk($sformatf("sim_pulse@%0d", k), 32'(btn_pulse),
          (k == ACC) ? 32'h5 : (k == ACC + 3) ? 32'h2 : 32'h0);
    end
    chk("sim_level", 32'(btn_level), 32'h7);
    btn_raw = 3'b000;
    repeat (20) step();
    chk("sim_idle_level", 32'(btn_level), 32'h0);

    // reset asserted mid-count with the button held, released after edge 12
    btn_raw = 3'b010;
    for (int k = 1; k <= 9; k++) step();
    res_n = 1'b0;
    #1;
    chk("mrst_level_async", 32'(btn_level), 32'h0);
    chk("mrst_pulse_async", 32'(btn_pulse), 32'h0);
    for (int k = 10; k <= 12; k++) begin
      step();
      chk($sformatf("mrst_hold_pulse@%0d", k), 32'(btn_pulse), 32'h0);
      chk($sformatf("mrst_hold_level@%0d", k), 32'(btn_level), 32'h0);
    end
    res_n = 1'b1;
    for (int k = 13; k <= 35; k++) begin
      step();
      chk($sformatf("mrst_pulse@%0d", k), 32'(btn_pulse), (k == 12 + ACC) ? 32'h2 : 32'h0);
      chk($sformatf("mrst_level@%0d", k), 32'(btn_level), (k >= 12 + ACC) ? 32'h2 : 32'h0);
    end

    // asynchronous reset clears an accepted level without waiting for an edge
    res_n = 1'b0;
    #1;
    chk("arst_level", 32'(btn_level), 32'h0);
    chk("arst_pulse", 32'(btn_pulse), 32'h0);
    btn_raw = 3'b000;
    step();
    res_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
